// File: rtl/bp_port_sched_pkg.sv
// Shared types and defaults for the branch-predictor port scheduler.
// Update FIFO entries are laid out as {idx, taken}, with taken in the LSB.
package bp_port_sched_pkg;

   localparam int ADDR_W         = 32;
   typedef logic [ADDR_W-1:0] addr_t;

   localparam int IDX_W_DEF      = 8;
   localparam int HIST_W_DEF     = 8;
   localparam int QDEPTH_DEF     = 4;
   localparam int STARVE_MAX_DEF = 3;

   localparam int UPD_TAKEN_LSB  = 0;
   localparam int UPD_IDX_LSB    = 1;

   function automatic int upd_entry_w(input int idx_w);
      return idx_w + 1;
   endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Committed-branch update FIFO; freezes entirely while rdy_in is low.
// Push when full and pop when empty are ignored.
module bp_upd_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
)(
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   input  logic             push_in,
   input  logic             pop_in,
   input  logic [WIDTH-1:0] wdata_in,
   output logic [WIDTH-1:0] rdata_out,
   output logic             full_out,
   output logic             empty_out
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign full_out  = (r_count == FULL_CNT);
   assign empty_out = (r_count == '0);
   assign rdata_out = r_mem[r_rd_ptr];

   assign w_do_push = rdy_in && push_in && !full_out;
   assign w_do_pop  = rdy_in && pop_in && !empty_out;

   always_ff @(posedge clk_in) begin
      if (w_do_push) r_mem[r_wr_ptr] <= wdata_in;
   end

   // Power-of-2 depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/bp_port_sched.sv
// Arbitrates the single-port pattern table between IF lookups and queued
// commit updates, and keeps the gshare GHRs. Optional BP_SCHED_STATS_EN adds counters.
module bp_port_sched
   import bp_port_sched_pkg::*;
#(
   parameter int IDX_W      = IDX_W_DEF,
   parameter int HIST_W     = HIST_W_DEF,
   parameter int QDEPTH     = QDEPTH_DEF,
   parameter int STARVE_MAX = STARVE_MAX_DEF
)(
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              clr_in,
   input  logic              if_lookup_valid_in,
   input  logic [ADDR_W-1:0] if_lookup_pc_in,
   output logic              if_lookup_grant_out,
   input  logic              if_pred_valid_in,
   input  logic              if_pred_taken_in,
   input  logic              rob_br_commit_in,
   input  logic              rob_br_taken_in,
   input  logic [ADDR_W-1:0] rob_br_pc_in,
   output logic              upd_full_out,
   output logic              tbl_en_out,
   output logic              tbl_we_out,
   output logic [IDX_W-1:0]  tbl_idx_out,
   output logic              tbl_taken_out,
`ifdef BP_SCHED_STATS_EN
   output logic [31:0]       stat_upd_out,
   output logic [31:0]       stat_force_out,
`endif
   output logic [HIST_W-1:0] ghr_spec_out
);

   localparam int ENT_W  = upd_entry_w(IDX_W);
   localparam int SCNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [SCNT_W-1:0] STARVE_LIM = SCNT_W'(STARVE_MAX);

   logic [HIST_W-1:0] r_ghr_spec;
   logic [HIST_W-1:0] r_ghr_commit;
   logic [HIST_W-1:0] w_ghr_commit_nxt;
   logic [SCNT_W-1:0] r_starve;
   logic              r_tbl_en;
   logic              r_tbl_we;
   logic [IDX_W-1:0]  r_tbl_idx;
   logic              r_tbl_taken;
   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic              w_arb;
   logic              w_grant;
   logic [IDX_W-1:0]  w_lk_idx;
   logic [IDX_W-1:0]  w_upd_idx;
   logic [ENT_W-1:0]  w_wdata;
   logic [ENT_W-1:0]  w_rdata;
   logic              w_unused_pc;

   assign w_lk_idx  = if_lookup_pc_in[IDX_W+1:2] ^ IDX_W'(r_ghr_spec);
   assign w_upd_idx = rob_br_pc_in[IDX_W+1:2] ^ IDX_W'(r_ghr_commit);
   assign w_wdata   = {w_upd_idx, rob_br_taken_in};

   // A flush cycle freezes the port: no grant and no pop, but pushes still land.
   assign w_arb   = rdy_in && !clr_in;
   assign w_grant = w_arb && if_lookup_valid_in && (w_empty || (r_starve < STARVE_LIM));
   assign w_pop   = w_arb && !w_empty && !w_grant;
   assign w_push  = rdy_in && rob_br_commit_in && !w_full;

   assign w_ghr_commit_nxt = w_push ? {r_ghr_commit[HIST_W-2:0], rob_br_taken_in}
                                    : r_ghr_commit;

   assign if_lookup_grant_out = rst_in && w_grant;
   assign upd_full_out        = w_full;
   assign tbl_en_out          = r_tbl_en;
   assign tbl_we_out          = r_tbl_we;
   assign tbl_idx_out         = r_tbl_idx;
   assign tbl_taken_out       = r_tbl_taken;
   assign ghr_spec_out        = r_ghr_spec;

   assign w_unused_pc = ^{if_lookup_pc_in[ADDR_W-1:IDX_W+2], if_lookup_pc_in[1:0],
                          rob_br_pc_in[ADDR_W-1:IDX_W+2], rob_br_pc_in[1:0]};

   bp_upd_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (QDEPTH)
   ) u_upd_fifo (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .rdy_in    (rdy_in),
      .push_in   (w_push),
      .pop_in    (w_pop),
      .wdata_in  (w_wdata),
      .rdata_out (w_rdata),
      .full_out  (w_full),
      .empty_out (w_empty)
   );

   // Flush restores the speculative history from the post-commit value.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_ghr_commit <= '0;
         r_ghr_spec   <= '0;
      end else if (rdy_in) begin
         r_ghr_commit <= w_ghr_commit_nxt;
         if (clr_in)                r_ghr_spec <= w_ghr_commit_nxt;
         else if (if_pred_valid_in) r_ghr_spec <= {r_ghr_spec[HIST_W-2:0], if_pred_taken_in};
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_starve <= '0;
      end else if (rdy_in) begin
         if (clr_in || w_pop)
            r_starve <= '0;
         else if (w_grant && !w_empty && (r_starve != STARVE_LIM))
            r_starve <= r_starve + 1'b1;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_tbl_en    <= 1'b0;
         r_tbl_we    <= 1'b0;
         r_tbl_idx   <= '0;
         r_tbl_taken <= 1'b0;
      end else if (w_grant) begin
         r_tbl_en    <= 1'b1;
         r_tbl_we    <= 1'b0;
         r_tbl_idx   <= w_lk_idx;
         r_tbl_taken <= 1'b0;
      end else if (w_pop) begin
         r_tbl_en    <= 1'b1;
         r_tbl_we    <= 1'b1;
         r_tbl_idx   <= w_rdata[ENT_W-1:UPD_IDX_LSB];
         r_tbl_taken <= w_rdata[UPD_TAKEN_LSB];
      end else begin
         r_tbl_en    <= 1'b0;
         r_tbl_we    <= 1'b0;
         r_tbl_idx   <= '0;
         r_tbl_taken <= 1'b0;
      end
   end

`ifdef BP_SCHED_STATS_EN
   logic [31:0] r_stat_upd;
   logic [31:0] r_stat_force;

   // A pop while a lookup is waiting only happens when starvation forced it.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_stat_upd   <= '0;
         r_stat_force <= '0;
      end else if (rdy_in) begin
         if (w_pop)                       r_stat_upd   <= r_stat_upd + 32'd1;
         if (w_pop && if_lookup_valid_in) r_stat_force <= r_stat_force + 32'd1;
      end
   end

   assign stat_upd_out   = r_stat_upd;
   assign stat_force_out = r_stat_force;
`endif

`ifndef SYNTHESIS
   always @(posedge clk_in) begin
      if (rdy_in && rob_br_commit_in && w_full)
         $warning("bp_port_sched: branch commit while update queue full, entry dropped");
   end
`endif

endmodule

// File: tb/tb_bp_port_sched.sv
// Scoreboard bench for bp_port_sched: directed scenarios plus a random phase.
// Table accesses are predicted when inputs are driven and compared one cycle later.
module tb_bp_port_sched;

   logic        clk_in;
   logic        rst_in;
   logic        rdy_in;
   logic        clr_in;
   logic        if_lookup_valid_in;
   logic [31:0] if_lookup_pc_in;
   logic        if_lookup_grant_out;
   logic        if_pred_valid_in;
   logic        if_pred_taken_in;
   logic        rob_br_commit_in;
   logic        rob_br_taken_in;
   logic [31:0] rob_br_pc_in;
   logic        upd_full_out;
   logic        tbl_en_out;
   logic        tbl_we_out;
   logic [7:0]  tbl_idx_out;
   logic        tbl_taken_out;
   logic [7:0]  ghr_spec_out;

   bp_port_sched dut (
      .clk_in              (clk_in),
      .rst_in              (rst_in),
      .rdy_in              (rdy_in),
      .clr_in              (clr_in),
      .if_lookup_valid_in  (if_lookup_valid_in),
      .if_lookup_pc_in     (if_lookup_pc_in),
      .if_lookup_grant_out (if_lookup_grant_out),
      .if_pred_valid_in    (if_pred_valid_in),
      .if_pred_taken_in    (if_pred_taken_in),
      .rob_br_commit_in    (rob_br_commit_in),
      .rob_br_taken_in     (rob_br_taken_in),
      .rob_br_pc_in        (rob_br_pc_in),
      .upd_full_out        (upd_full_out),
      .tbl_en_out          (tbl_en_out),
      .tbl_we_out          (tbl_we_out),
      .tbl_idx_out         (tbl_idx_out),
      .tbl_taken_out       (tbl_taken_out),
      .ghr_spec_out        (ghr_spec_out)
   );

   // clock / reset
   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // scoreboard: {en, we, idx[7:0], taken}
   logic [10:0] exp_q[$];
   logic [8:0]  m_fifo[$];
   int          m_starve;
   logic [7:0]  m_ghr_spec;
   logic [7:0]  m_ghr_commit;
   int          n_vec;
   int          n_err;

   logic        dir_on;
   string       dir_tag;
   int          dir_sel;
   logic [31:0] dir_exp;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_dir(input string tag, input int sel, input logic [31:0] exp);
      dir_on  = 1'b1;
      dir_tag = tag;
      dir_sel = sel;
      dir_exp = exp;
   endtask

   // One clock cycle: check last edge's results, drive, predict, advance model.
   task automatic step(input logic lv, input logic [31:0] pc, input logic pv, input logic pt,
                       input logic cv, input logic ct, input logic [31:0] cpc,
                       input logic clr, input logic rdy, output logic g_obs);
      logic [10:0] e;
      logic        m_empty;
      logic        m_full;
      logic        m_grant;
      logic        m_pop;
      logic        m_push;
      logic [7:0]  lk;
      logic [8:0]  head;
      @(negedge clk_in);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("tbl", 32'({tbl_en_out, tbl_we_out, tbl_idx_out, tbl_taken_out}), 32'(e));
      end
      check("ghr_spec", 32'(ghr_spec_out), 32'(m_ghr_spec));
      check("full", 32'(upd_full_out), 32'(m_fifo.size() == 4));
      if (dir_on) begin
         case (dir_sel)
            0:       check(dir_tag, 32'({tbl_en_out, tbl_we_out, tbl_idx_out, tbl_taken_out}), dir_exp);
            1:       check(dir_tag, 32'(ghr_spec_out), dir_exp);
            default: check(dir_tag, 32'(upd_full_out), dir_exp);
         endcase
         dir_on = 1'b0;
      end
      if_lookup_valid_in = lv;
      if_lookup_pc_in    = pc;
      if_pred_valid_in   = pv;
      if_pred_taken_in   = pt;
      rob_br_commit_in   = cv;
      rob_br_taken_in    = ct;
      rob_br_pc_in       = cpc;
      clr_in             = clr;
      rdy_in             = rdy;
      #1;
      m_empty = (m_fifo.size() == 0);
      m_full  = (m_fifo.size() == 4);
      m_grant = rdy && !clr && lv && (m_empty || (m_starve < 3));
      m_pop   = rdy && !clr && !m_empty && !m_grant;
      m_push  = rdy && cv && !m_full;
      g_obs   = if_lookup_grant_out;
      check("grant", 32'(if_lookup_grant_out), 32'(m_grant));
      lk   = pc[9:2] ^ m_ghr_spec;
      head = m_empty ? 9'd0 : m_fifo[0];
      if (m_grant)    e = {2'b10, lk, 1'b0};
      else if (m_pop) e = {2'b11, head};
      else            e = 11'd0;
      exp_q.push_back(e);
      if (rdy) begin
         if (m_pop) void'(m_fifo.pop_front());
         if (m_push) begin
            m_fifo.push_back({cpc[9:2] ^ m_ghr_commit, ct});
            m_ghr_commit = {m_ghr_commit[6:0], ct};
         end
         if (clr)     m_ghr_spec = m_ghr_commit;
         else if (pv) m_ghr_spec = {m_ghr_spec[6:0], pt};
         if (clr || m_pop)                          m_starve = 0;
         else if (m_grant && !m_empty && m_starve < 3) m_starve++;
      end
   endtask

   task automatic idle(input int n);
      logic g;
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, g);
   endtask

   // Asynchronous reset in the middle of a low clock phase.
   task automatic do_reset();
      @(negedge clk_in);
      #2;
      rst_in = 1'b0;
      #1;
      check("rst_tbl_en", 32'(tbl_en_out), 32'd0);
      check("rst_ghr", 32'(ghr_spec_out), 32'd0);
      check("rst_full", 32'(upd_full_out), 32'd0);
      check("rst_grant", 32'(if_lookup_grant_out), 32'd0);
      m_fifo.delete();
      exp_q.delete();
      m_ghr_spec   = 8'd0;
      m_ghr_commit = 8'd0;
      m_starve     = 0;
      dir_on       = 1'b0;
      if_lookup_valid_in = 1'b0;
      if_pred_valid_in   = 1'b0;
      rob_br_commit_in   = 1'b0;
      clr_in             = 1'b0;
      rdy_in             = 1'b1;
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b1;
   endtask

   initial begin
      logic       g;
      logic [3:0] gr;
      logic [7:0] saved;
      n_vec = 0;
      n_err = 0;
      dir_on = 1'b0;
      dir_tag = "";
      dir_sel = 0;
      dir_exp = 32'd0;
      m_starve = 0;
      m_ghr_spec = 8'd0;
      m_ghr_commit = 8'd0;
      rst_in = 1'b0;
      rdy_in = 1'b1;
      clr_in = 1'b0;
      if_lookup_valid_in = 1'b1;
      if_lookup_pc_in = 32'h0000_0104;
      if_pred_valid_in = 1'b0;
      if_pred_taken_in = 1'b0;
      rob_br_commit_in = 1'b0;
      rob_br_taken_in = 1'b0;
      rob_br_pc_in = 32'd0;
      #3;
      check("init_tbl_en", 32'(tbl_en_out), 32'd0);
      check("init_grant", 32'(if_lookup_grant_out), 32'd0);
      check("init_ghr", 32'(ghr_spec_out), 32'd0);
      if_lookup_valid_in = 1'b0;
      @(negedge clk_in);
      rst_in = 1'b1;

      // Lookup index: ghr_spec = 0x05, PC 0x104 -> 0x41 ^ 0x05 = 0x44
      step(0, 0, 1, 1, 0, 0, 0, 0, 1, g);
      step(0, 0, 1, 0, 0, 0, 0, 0, 1, g);
      step(0, 0, 1, 1, 0, 0, 0, 0, 1, g);
      set_dir("lk_ghr", 1, 32'h05);
      step(1, 32'h0000_0104, 0, 0, 0, 0, 0, 0, 1, g);
      check("lk_grant", 32'(g), 32'd1);
      set_dir("lk_tbl", 0, 32'({2'b10, 8'h44, 1'b0}));
      idle(1);

      // Starvation: one queued update against continuous lookups
      do_reset();
      for (int r = 0; r < 2; r++) begin
         step(0, 0, 0, 0, 1, 1, 32'h0000_0200, 0, 1, g);
         for (int i = 0; i < 4; i++) begin
            step(1, 32'h0000_0300 + 32'(i * 4), 0, 0, 0, 0, 0, 0, 1, g);
            gr[i] = g;
         end
         check("starve_grants", 32'(gr), 32'h7);
         if (r == 0) set_dir("starve_upd", 0, 32'({2'b11, 8'h80, 1'b1}));
         step(1, 32'h0000_0340, 0, 0, 0, 0, 0, 0, 1, g);
         check("starve_regrant", 32'(g), 32'd1);
      end
      idle(2);

      // Fill under flush (no pops), drop on full, push+pop at count 2
      do_reset();
      step(0, 0, 0, 0, 1, 1, 32'h10, 1, 1, g);
      step(0, 0, 0, 0, 1, 1, 32'h20, 1, 1, g);
      step(0, 0, 0, 0, 1, 0, 32'h30, 1, 1, g);
      step(0, 0, 0, 0, 1, 1, 32'h40, 1, 1, g);
      set_dir("fill_full", 2, 32'd1);
      step(0, 0, 0, 0, 1, 1, 32'h50, 1, 1, g);
      set_dir("drop_ghr_commit", 1, 32'h0D);
      step(0, 0, 0, 0, 0, 0, 0, 1, 1, g);
      idle(2);
      step(0, 0, 0, 0, 1, 0, 32'h64, 0, 1, g);
      step(0, 0, 0, 0, 1, 1, 32'h68, 1, 1, g);
      step(0, 0, 0, 0, 1, 0, 32'h6C, 1, 1, g);
      set_dir("pushpop_full", 2, 32'd1);
      idle(6);

      // Mid-traffic reset with two entries queued
      step(0, 0, 1, 1, 1, 1, 32'h80, 1, 1, g);
      step(1, 32'h84, 1, 1, 1, 0, 32'h88, 1, 1, g);
      do_reset();
      idle(4);

      // Flush: ghr_commit = 0x0A, ghr_spec = 0xFF, then clr with a taken commit
      for (int i = 0; i < 4; i++)
         step(1, 32'h400 + 32'(i * 4), 1, 1, 1, (i % 2 == 0), 32'h500 + 32'(i * 8), 0, 1, g);
      for (int i = 0; i < 4; i++)
         step(1, 32'h410 + 32'(i * 4), 1, 1, 0, 0, 0, 0, 1, g);
      set_dir("pre_flush_ghr", 1, 32'hFF);
      step(1, 32'h420, 1, 0, 1, 1, 32'h540, 1, 1, g);
      check("flush_grant", 32'(g), 32'd0);
      set_dir("flush_ghr", 1, 32'h15);
      idle(6);

      // rdy_in low for 3 cycles with pending lookup and queue
      step(1, 32'h600, 0, 0, 1, 1, 32'h700, 0, 1, g);
      step(1, 32'h604, 0, 0, 1, 0, 32'h704, 0, 1, g);
      saved = m_ghr_spec;
      for (int i = 0; i < 3; i++) begin
         step(1, 32'h608, 1, 1, 1, 1, 32'h708, 0, 0, g);
         check("rdy_low_grant", 32'(g), 32'd0);
      end
      set_dir("rdy_low_ghr", 1, 32'(saved));
      for (int i = 0; i < 4; i++) step(1, 32'h60C, 0, 0, 0, 0, 0, 0, 1, g);
      idle(5);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 1), $urandom(), $urandom_range(0, 1), $urandom_range(0, 1),
              ($urandom_range(0, 2) != 0) && (m_fifo.size() < 4), $urandom_range(0, 1),
              $urandom(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0), g);
      end
      idle(8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
